// File: rtl/switch_press_counter.sv
// switch_press_counter: counts debounced switch releases as two BCD digits with registered seven-segment outputs.
// Define AUTO_REPEAT_EN to add hold-to-repeat increments (HOLD_CYCLES / REPEAT_CYCLES).
module switch_press_counter #(
   parameter int unsigned HOLD_CYCLES   = 12500000,
   parameter int unsigned REPEAT_CYCLES = 2500000
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Switch,
   input  logic       i_Clear,
   output logic [3:0] o_Ones,
   output logic [3:0] o_Tens,
   output logic [6:0] o_Seg_Ones,
   output logic [6:0] o_Seg_Tens,
   output logic       o_Wrap
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PRESSED = 2'd1;
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 2**24 || REPEAT_CYCLES < 1 || REPEAT_CYCLES > 2**24) begin : g_bad_cfg
      $error("HOLD_CYCLES and REPEAT_CYCLES must be in 1..2**24");
   end
   logic [1:0] state_q, state_d;
   logic       switch_q;
   logic [3:0] ones_q, ones_d, tens_q, tens_d;
   logic       wrap_q, wrap_d;
   logic [6:0] seg_ones_q, seg_tens_q;
   logic       release_w, inc;
`ifdef AUTO_REPEAT_EN
   localparam logic [1:0]  REPEAT   = 2'd2;
   localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);
   localparam logic [23:0] REP_LAST  = 24'(REPEAT_CYCLES - 1);
   logic [23:0] hold_q, hold_d, rep_q, rep_d;
`endif
   assign release_w = switch_q & ~i_Switch;
   always_comb begin
      state_d = state_q;
      inc     = 1'b0;
`ifdef AUTO_REPEAT_EN
      hold_d  = hold_q + 24'd1;
      rep_d   = rep_q + 24'd1;
`endif
      if (state_q == IDLE) begin
         if (i_Switch) state_d = PRESSED;
      end else if (state_q == PRESSED) begin
         if (release_w) begin
            inc     = 1'b1;
            state_d = IDLE;
         end
`ifdef AUTO_REPEAT_EN
         else if (hold_q == HOLD_LAST) begin
            inc     = 1'b1;
            state_d = REPEAT;
         end
      end else begin
         // a repeat tick coinciding with the release still counts; the release itself adds nothing
         if (rep_q == REP_LAST) begin
            inc   = 1'b1;
            rep_d = 24'd0;
         end
         if (release_w) state_d = IDLE;
      end
      if (state_d != state_q) begin
         hold_d = 24'd0;
         rep_d  = 24'd0;
      end
`else
      end
`endif
   end
   always_comb begin
      ones_d = ones_q;
      tens_d = tens_q;
      wrap_d = 1'b0;
      if (i_Clear) begin
         ones_d = 4'd0;
         tens_d = 4'd0;
      end else if (inc) begin
         ones_d = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
         tens_d = (ones_q != 4'd9) ? tens_q : (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
         wrap_d = (ones_q == 4'd9) && (tens_q == 4'd9);
      end
   end
   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = 7'h7F;
      endcase
   endfunction
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q    <= IDLE;
         switch_q   <= 1'b0;
         ones_q     <= 4'd0;
         tens_q     <= 4'd0;
         wrap_q     <= 1'b0;
         seg_ones_q <= 7'h40;
         seg_tens_q <= 7'h40;
      end else begin
         state_q    <= state_d;
         switch_q   <= i_Switch;
         ones_q     <= ones_d;
         tens_q     <= tens_d;
         wrap_q     <= wrap_d;
         seg_ones_q <= seg(ones_q);
         seg_tens_q <= seg(tens_q);
      end
   end
`ifdef AUTO_REPEAT_EN
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         hold_q <= 24'd0;
         rep_q  <= 24'd0;
      end else begin
         hold_q <= hold_d;
         rep_q  <= rep_d;
      end
   end
`endif
   assign o_Ones     = ones_q;
   assign o_Tens     = tens_q;
   assign o_Wrap     = wrap_q;
   assign o_Seg_Ones = seg_ones_q;
   assign o_Seg_Tens = seg_tens_q;
endmodule
